// File: rtl/seq_mult_slice_engine.sv
// seq_mult_slice_engine: sequential DATA_W x DATA_W multiplier, one SLICE_W x SLICE_W partial product per clock
module seq_mult_slice_engine #(
  parameter int SLICE_W = 4,
  parameter int NSLICE  = 2
) (
  input  logic                                   clk,
  input  logic                                   reset_an,
  input  logic                                   start,
  input  logic [SLICE_W*NSLICE-1:0]              data_a,
  input  logic [SLICE_W*NSLICE-1:0]              data_b,
  output logic [2*SLICE_W*NSLICE-1:0]            product,
  output logic                                   done,
  output logic                                   busy,
  output logic                                   err,
  output logic [1:0]                             state_out,
  output logic [((NSLICE*NSLICE > 1) ? $clog2(NSLICE*NSLICE) : 1)-1:0] step_out
);
  localparam int DATA_W = SLICE_W * NSLICE;
  localparam int N      = NSLICE * NSLICE;
  localparam int KW     = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, DONE = 2'b10, ERR = 2'b11} state_t;
  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [2*DATA_W-1:0] acc_q, acc_d, product_q, product_d, sum;
  logic [SLICE_W-1:0]  a_sl, b_sl;
  logic [2*SLICE_W-1:0] pp;
  logic                accept, step, last;
  always_comb begin
    a_sl      = a_q[(int'(k_q) % NSLICE)*SLICE_W +: SLICE_W];
    b_sl      = b_q[(int'(k_q) / NSLICE)*SLICE_W +: SLICE_W];
    pp        = {{SLICE_W{1'b0}}, a_sl} * {{SLICE_W{1'b0}}, b_sl};
    sum       = acc_q + ((2*DATA_W)'(pp) << (SLICE_W*(int'(k_q) % NSLICE + int'(k_q) / NSLICE)));
    accept    = start && (state_q == IDLE || state_q == ERR);
    step      = state_q == CALC && !start;
    last      = k_q == KW'(N-1);
    state_d   = accept ? CALC :
                state_q == CALC ? (start ? ERR : last ? DONE : CALC) :
                state_q == DONE ? (start ? ERR : IDLE) : state_q;
    a_d       = accept ? data_a : a_q;
    b_d       = accept ? data_b : b_q;
    acc_d     = accept ? '0 : step ? sum : acc_q;
    k_d       = (step && !last) ? k_q + KW'(1) : '0;
    product_d = (step && last) ? sum : product_q;
  end
  always_ff @(posedge clk or negedge reset_an) begin
    if (!reset_an) begin
      state_q   <= IDLE;
      k_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end
  assign product   = product_q;
  assign done      = state_q == DONE;
  assign busy      = state_q == CALC || state_q == DONE;
  assign err       = state_q == ERR;
  assign state_out = state_q;
  assign step_out  = k_q;
endmodule

// File: tb/tb_seq_mult_slice_engine.sv
// tb_seq_mult_slice_engine: scoreboard bench for default and 4-slice engine instances
module tb_seq_mult_slice_engine;
  logic clk = 0;
  logic reset_an = 0;
  always #5 clk = ~clk;
  logic s0 = 0, s1 = 0;
  logic [7:0] a0 = 0, b0 = 0;
  logic [15:0] a1 = 0, b1 = 0;
  logic [15:0] p0;
  logic [31:0] p1;
  logic d0, bz0, e0, d1, bz1, e1;
  logic [1:0] st0, st1, k0;
  logic [3:0] k1;
  int checks = 0, errors = 0;
  logic [15:0] q0[$];
  logic [31:0] q1[$];
  seq_mult_slice_engine dut0 (
    .clk(clk), .reset_an(reset_an), .start(s0), .data_a(a0), .data_b(b0),
    .product(p0), .done(d0), .busy(bz0), .err(e0), .state_out(st0), .step_out(k0)
  );
  seq_mult_slice_engine #(.SLICE_W(4), .NSLICE(4)) dut1 (
    .clk(clk), .reset_an(reset_an), .start(s1), .data_a(a1), .data_b(b1),
    .product(p1), .done(d1), .busy(bz1), .err(e1), .state_out(st1), .step_out(k1)
  );
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endfunction
  always @(negedge clk) if (reset_an && d0) begin
    if (q0.size() == 0) chk("unexpected_done0", 32'(d0), 0);
    else chk("product0", 32'(p0), 32'(q0.pop_front()));
  end
  always @(negedge clk) if (reset_an && d1) begin
    if (q1.size() == 0) chk("unexpected_done1", 32'(d1), 0);
    else chk("product1", p1, q1.pop_front());
  end
  task automatic wait_done(input int inst);
    int n;
    n = 0;
    while (!(inst == 1 ? d1 : d0) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), inst == 1 ? 16 : 4);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(inst == 1 ? d1 : d0), 0);
    chk("back_to_idle", 32'(inst == 1 ? st1 : st0), 0);
  endtask
  task automatic run(input int inst, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    if (inst == 0) begin
      s0 = 1; a0 = a[7:0]; b0 = b[7:0];
      q0.push_back(16'(a[7:0]) * 16'(b[7:0]));
    end else begin
      s1 = 1; a1 = a; b1 = b;
      q1.push_back(32'(a) * 32'(b));
    end
    @(posedge clk); #1;
    s0 = 0; s1 = 0;
    a0 = 8'($urandom); b0 = 8'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
    chk("busy_calc", 32'(inst == 1 ? bz1 : bz0), 1);
    wait_done(inst);
  endtask
  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_product0", 32'(p0), 0);
    chk("rst_done0", 32'(d0), 0);
    chk("rst_busy0", 32'(bz0), 0);
    chk("rst_err0", 32'(e0), 0);
    chk("rst_state0", 32'(st0), 0);
    chk("rst_step0", 32'(k0), 0);
    chk("rst_product1", p1, 0);
    @(negedge clk) reset_an = 1;
    run(0, 16'hFF, 16'hFF);
    chk("t1_product", 32'(p0), 32'h0000FE01);
    run(0, 16'h00, 16'hA5);
    chk("t2a_product", 32'(p0), 0);
    run(0, 16'h12, 16'h34);
    chk("t2b_product", 32'(p0), 32'h03A8);
    @(negedge clk);
    s0 = 1; a0 = 8'h77; b0 = 8'h99;
    @(posedge clk); #1;
    chk("t3_calc", 32'(st0), 1);
    @(posedge clk); #1;
    chk("t3_err", 32'(e0), 1);
    chk("t3_state_err", 32'(st0), 3);
    chk("t3_product_kept", 32'(p0), 32'h03A8);
    a0 = 8'h0F; b0 = 8'h10;
    q0.push_back(16'h00F0);
    @(posedge clk); #1;
    s0 = 0;
    chk("t4_err_drop", 32'(e0), 0);
    chk("t4_calc", 32'(st0), 1);
    wait_done(0);
    chk("t4_product", 32'(p0), 32'h00F0);
    @(negedge clk);
    s0 = 1; a0 = 8'($urandom); b0 = 8'($urandom);
    @(posedge clk); #1;
    s0 = 0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("t5_step2", 32'(k0), 2);
    #2 reset_an = 0;
    #1;
    chk("t5_product", 32'(p0), 0);
    chk("t5_state", 32'(st0), 0);
    chk("t5_busy", 32'(bz0), 0);
    chk("t5_step", 32'(k0), 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("t5_no_done", 32'(d0), 0);
    end
    @(negedge clk) reset_an = 1;
    repeat (20) run(0, 16'($urandom), 16'($urandom));
    run(1, 16'hFFFF, 16'hFFFF);
    chk("t6_product", p1, 32'hFFFE0001);
    repeat (4) run(1, 16'($urandom), 16'($urandom));
    repeat (2) @(posedge clk);
    chk("sb_empty0", 32'(q0.size()), 0);
    chk("sb_empty1", 32'(q1.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
